// File: rtl/tl_rx_vc_ordering_arbiter_if.sv
// Read side of the RX VC sequence/header/data FIFOs, the TLP output stream toward
// the AXI bridge and the flow-control credit-return strobe, as seen by the arbiter.
interface tl_rx_vc_ordering_arbiter_if #(
   parameter int HDR_WIDTH  = 128,
   parameter int DATA_WIDTH = 256
);
   logic                  i_seq_empty;
   logic                  i_seq_type;
   logic                  o_seq_r_inc;

   logic                  i_p_hdr_empty;
   logic                  i_np_hdr_empty;
   logic [HDR_WIDTH-1:0]  i_p_hdr;
   logic [HDR_WIDTH-1:0]  i_np_hdr;
   logic                  o_p_hdr_r_inc;
   logic                  o_np_hdr_r_inc;

   logic                  i_p_data_empty;
   logic                  i_np_data_empty;
   logic [DATA_WIDTH-1:0] i_p_data;
   logic [DATA_WIDTH-1:0] i_np_data;
   logic                  o_p_data_r_inc;
   logic                  o_np_data_r_inc;

   logic                  o_tlp_valid;
   logic                  o_tlp_sop;
   logic                  o_tlp_eop;
   logic                  o_tlp_is_hdr;
   logic                  o_tlp_type;
   logic [DATA_WIDTH-1:0] o_tlp_data;
   logic                  i_tlp_ready;

   logic                  o_cr_valid;
   logic                  o_cr_type;
   logic [10:0]           o_cr_data;

   modport master (
      input  i_seq_empty, i_seq_type,
      output o_seq_r_inc,
      input  i_p_hdr_empty, i_np_hdr_empty, i_p_hdr, i_np_hdr,
      output o_p_hdr_r_inc, o_np_hdr_r_inc,
      input  i_p_data_empty, i_np_data_empty, i_p_data, i_np_data,
      output o_p_data_r_inc, o_np_data_r_inc,
      output o_tlp_valid, o_tlp_sop, o_tlp_eop, o_tlp_is_hdr, o_tlp_type, o_tlp_data,
      input  i_tlp_ready,
      output o_cr_valid, o_cr_type, o_cr_data
   );

   modport slave (
      output i_seq_empty, i_seq_type,
      input  o_seq_r_inc,
      output i_p_hdr_empty, i_np_hdr_empty, i_p_hdr, i_np_hdr,
      input  o_p_hdr_r_inc, o_np_hdr_r_inc,
      output i_p_data_empty, i_np_data_empty, i_p_data, i_np_data,
      input  o_p_data_r_inc, o_np_data_r_inc,
      input  o_tlp_valid, o_tlp_sop, o_tlp_eop, o_tlp_is_hdr, o_tlp_type, o_tlp_data,
      output i_tlp_ready,
      input  o_cr_valid, o_cr_type, o_cr_data
   );
endinterface

// File: rtl/tl_rx_vc_ordering_arbiter.sv
// Drains the RX VC posted/non-posted FIFOs in strict arrival order, emitting each TLP
// as a header beat plus payload beats and returning flow-control credits on completion.
module tl_rx_vc_ordering_arbiter #(
   parameter int HDR_WIDTH  = 128,
   parameter int DATA_WIDTH = 256
) (
   input  logic                        i_clk,
   input  logic                        i_n_rst,
   tl_rx_vc_ordering_arbiter_if.master bus
);
   localparam int DW_PER_BEAT = DATA_WIDTH / 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [HDR_WIDTH-1:0]  hdr_q, hdr_d;
   logic                  type_q, type_d;
   logic [10:0]           cnt_q, cnt_d;
   logic                  cr_valid_q, cr_valid_d;
   logic                  cr_type_q, cr_type_d;
   logic [10:0]           cr_data_q, cr_data_d;

   logic                  sel_hdr_empty_s;
   logic [HDR_WIDTH-1:0]  sel_hdr_s;
   logic                  sel_data_empty_s;
   logic [DATA_WIDTH-1:0] sel_data_s;
   logic                  has_data_s;
   logic [10:0]           len_dw_s;
   logic                  capture_s;
   logic                  accept_s;

   // A Length field of zero encodes the 1024-DW maximum.
   function automatic logic [10:0] f_len_dw(input logic [9:0] len_field);
      logic [10:0] len;
      if (len_field == 10'd0) begin
         len = 11'd1024;
      end else begin
         len = {1'b0, len_field};
      end
      return len;
   endfunction

   function automatic logic [10:0] f_beats(input logic [10:0] len);
      logic [10:0] sum;
      sum = len + 11'(DW_PER_BEAT - 1);
      return sum / 11'(DW_PER_BEAT);
   endfunction

   function automatic logic [10:0] f_credits(input logic [10:0] len);
      return 11'((len + 11'd3) >> 2);
   endfunction

   // FIFO selection: sequence head picks the header FIFO, the latched type picks data.
   always_comb begin
      sel_hdr_empty_s  = bus.i_seq_type ? bus.i_np_hdr_empty : bus.i_p_hdr_empty;
      sel_hdr_s        = bus.i_seq_type ? bus.i_np_hdr : bus.i_p_hdr;
      sel_data_empty_s = type_q ? bus.i_np_data_empty : bus.i_p_data_empty;
      sel_data_s       = type_q ? bus.i_np_data : bus.i_p_data;
      has_data_s       = hdr_q[30];
      len_dw_s         = f_len_dw(hdr_q[9:0]);
      capture_s        = i_n_rst & ~bus.i_seq_empty & ~sel_hdr_empty_s;
      accept_s         = ~sel_data_empty_s & bus.i_tlp_ready;
   end

   // Next-state, pops and stream outputs.
   always_comb begin
      state_d    = state_q;
      hdr_d      = hdr_q;
      type_d     = type_q;
      cnt_d      = cnt_q;
      cr_valid_d = 1'b0;
      cr_type_d  = 1'b0;
      cr_data_d  = 11'd0;

      bus.o_seq_r_inc     = 1'b0;
      bus.o_p_hdr_r_inc   = 1'b0;
      bus.o_np_hdr_r_inc  = 1'b0;
      bus.o_p_data_r_inc  = 1'b0;
      bus.o_np_data_r_inc = 1'b0;
      bus.o_tlp_valid     = 1'b0;
      bus.o_tlp_sop       = 1'b0;
      bus.o_tlp_eop       = 1'b0;
      bus.o_tlp_is_hdr    = 1'b0;
      bus.o_tlp_type      = 1'b0;
      bus.o_tlp_data      = {DATA_WIDTH{1'b0}};

      case (state_q)
         ST_IDLE: begin
            // The head entry blocks everything behind it until its header exists.
            if (capture_s) begin
               bus.o_seq_r_inc    = 1'b1;
               bus.o_p_hdr_r_inc  = ~bus.i_seq_type;
               bus.o_np_hdr_r_inc = bus.i_seq_type;
               hdr_d              = sel_hdr_s;
               type_d             = bus.i_seq_type;
               state_d            = ST_HDR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HDR: begin
            bus.o_tlp_valid  = 1'b1;
            bus.o_tlp_sop    = 1'b1;
            bus.o_tlp_is_hdr = 1'b1;
            bus.o_tlp_eop    = ~has_data_s;
            bus.o_tlp_type   = type_q;
            bus.o_tlp_data   = DATA_WIDTH'(hdr_q);
            if (bus.i_tlp_ready) begin
               if (has_data_s) begin
                  cnt_d   = f_beats(len_dw_s);
                  state_d = ST_DATA;
               end else begin
                  cr_valid_d = 1'b1;
                  cr_type_d  = type_q;
                  cr_data_d  = 11'd0;
                  state_d    = ST_IDLE;
               end
            end else begin
               state_d = ST_HDR;
            end
         end
         ST_DATA: begin
            bus.o_tlp_valid     = ~sel_data_empty_s;
            bus.o_tlp_type      = type_q;
            bus.o_tlp_data      = sel_data_s;
            bus.o_tlp_eop       = (cnt_q == 11'd1);
            bus.o_p_data_r_inc  = accept_s & ~type_q;
            bus.o_np_data_r_inc = accept_s & type_q;
            if (accept_s) begin
               cnt_d = cnt_q - 11'd1;
               if (cnt_q == 11'd1) begin
                  cr_valid_d = 1'b1;
                  cr_type_d  = type_q;
                  cr_data_d  = f_credits(len_dw_s);
                  state_d    = ST_IDLE;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, captured header and credit-return registers.
   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         state_q    <= ST_IDLE;
         hdr_q      <= {HDR_WIDTH{1'b0}};
         type_q     <= 1'b0;
         cnt_q      <= 11'd0;
         cr_valid_q <= 1'b0;
         cr_type_q  <= 1'b0;
         cr_data_q  <= 11'd0;
      end else begin
         state_q    <= state_d;
         hdr_q      <= hdr_d;
         type_q     <= type_d;
         cnt_q      <= cnt_d;
         cr_valid_q <= cr_valid_d;
         cr_type_q  <= cr_type_d;
         cr_data_q  <= cr_data_d;
      end
   end

   assign bus.o_cr_valid = cr_valid_q;
   assign bus.o_cr_type  = cr_type_q;
   assign bus.o_cr_data  = cr_data_q;
endmodule

// File: tb/tb_tl_rx_vc_ordering_arbiter.sv
// Directed bench: FIFO models feed the arbiter, a scoreboard holds the expected beat
// and credit-return streams, and a negedge monitor compares what the DUT produces.
module tb_tl_rx_vc_ordering_arbiter;
   localparam int HW  = 128;
   localparam int DWD = 256;

   typedef struct packed {
      logic           sop;
      logic           eop;
      logic           is_hdr;
      logic           typ;
      logic [DWD-1:0] data;
   } beat_t;

   typedef struct packed {
      logic        typ;
      logic [10:0] data;
   } cr_t;

   logic clk   = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   tl_rx_vc_ordering_arbiter_if #(.HDR_WIDTH(HW), .DATA_WIDTH(DWD)) bus ();

   tl_rx_vc_ordering_arbiter #(.HDR_WIDTH(HW), .DATA_WIDTH(DWD)) dut (
      .i_clk   (clk),
      .i_n_rst (n_rst),
      .bus     (bus.master)
   );

   bit             seq_q[$];
   logic [HW-1:0]  p_hdr_q[$];
   logic [HW-1:0]  np_hdr_q[$];
   logic [DWD-1:0] p_dat_q[$];
   logic [DWD-1:0] np_dat_q[$];
   beat_t          exp_beats[$];
   cr_t            exp_cr[$];

   int n_checks = 0;
   int n_fail   = 0;
   int acc_cnt  = 0;
   int n_seq = 0, n_p_hdr = 0, n_np_hdr = 0, n_p_dat = 0, n_np_dat = 0;
   bit pend_seq, pend_p_hdr, pend_np_hdr, pend_p_dat, pend_np_dat;

   task automatic check(input string tag, input logic [DWD-1:0] obs, input logic [DWD-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DWD-1:0] pat(input logic [15:0] tag, input int i);
      return {8{tag, 16'(i)}};
   endfunction

   task automatic send_tlp(input logic typ, input logic [2:0] fmt, input logic [9:0] len,
                           input logic [15:0] tag, input bit push_hdr, output logic [HW-1:0] hdr);
      beat_t b;
      cr_t   c;
      int    ndw, nbeats, ncred;
      hdr    = {16'hC0DE, tag, 32'h0BAD_F00D, 32'h1357_9BDF, fmt, 5'b00000, 14'h0000, len};
      ndw    = (len == 10'd0) ? 1024 : int'(len);
      nbeats = fmt[1] ? (ndw + 7) / 8 : 0;
      ncred  = fmt[1] ? (ndw + 3) / 4 : 0;
      seq_q.push_back(typ);
      if (push_hdr) begin
         if (typ) np_hdr_q.push_back(hdr);
         else     p_hdr_q.push_back(hdr);
      end
      b.sop = 1'b1; b.eop = ~fmt[1]; b.is_hdr = 1'b1; b.typ = typ; b.data = {128'h0, hdr};
      exp_beats.push_back(b);
      for (int i = 0; i < nbeats; i++) begin
         if (typ) np_dat_q.push_back(pat(tag, i));
         else     p_dat_q.push_back(pat(tag, i));
         b.sop = 1'b0; b.eop = (i == nbeats - 1); b.is_hdr = 1'b0; b.data = pat(tag, i);
         exp_beats.push_back(b);
      end
      c.typ = typ; c.data = 11'(ncred);
      exp_cr.push_back(c);
   endtask

   task automatic wait_done(input string tag, input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         if (exp_beats.size() == 0 && exp_cr.size() == 0) break;
         @(posedge clk);
      end
      @(posedge clk);
      #2;
      check(tag, exp_beats.size() + exp_cr.size(), 0);
   endtask

   // Monitor: record pops and compare accepted beats / credit pulses with the scoreboard.
   always @(negedge clk) begin
      beat_t eb;
      cr_t   ec;
      pend_seq    = bus.o_seq_r_inc;
      pend_p_hdr  = bus.o_p_hdr_r_inc;
      pend_np_hdr = bus.o_np_hdr_r_inc;
      pend_p_dat  = bus.o_p_data_r_inc;
      pend_np_dat = bus.o_np_data_r_inc;
      if (bus.o_tlp_valid === 1'b1 && bus.i_tlp_ready === 1'b1) begin
         acc_cnt++;
         check("beat_expected", exp_beats.size() != 0, 1'b1);
         if (exp_beats.size() != 0) begin
            eb = exp_beats.pop_front();
            check("beat_flags", {bus.o_tlp_sop, bus.o_tlp_eop, bus.o_tlp_is_hdr, bus.o_tlp_type},
                  {eb.sop, eb.eop, eb.is_hdr, eb.typ});
            check("beat_data", bus.o_tlp_data, eb.data);
         end
      end
      if (bus.o_cr_valid !== 1'b0) begin
         check("cr_expected", exp_cr.size() != 0, 1'b1);
         if (exp_cr.size() != 0) begin
            ec = exp_cr.pop_front();
            check("cr_type_data", {bus.o_cr_type, bus.o_cr_data}, {ec.typ, ec.data});
         end
      end
   end

   // FIFO model: apply the pops the DUT issued at the edge, then present new heads.
   always begin
      @(posedge clk);
      #1;
      if (pend_seq) begin
         check("seq_pop_nonempty", seq_q.size() != 0, 1'b1);
         if (seq_q.size() != 0) void'(seq_q.pop_front());
         n_seq++;
      end
      if (pend_p_hdr) begin
         check("p_hdr_pop_nonempty", p_hdr_q.size() != 0, 1'b1);
         if (p_hdr_q.size() != 0) void'(p_hdr_q.pop_front());
         n_p_hdr++;
      end
      if (pend_np_hdr) begin
         check("np_hdr_pop_nonempty", np_hdr_q.size() != 0, 1'b1);
         if (np_hdr_q.size() != 0) void'(np_hdr_q.pop_front());
         n_np_hdr++;
      end
      if (pend_p_dat) begin
         check("p_data_pop_nonempty", p_dat_q.size() != 0, 1'b1);
         if (p_dat_q.size() != 0) void'(p_dat_q.pop_front());
         n_p_dat++;
      end
      if (pend_np_dat) begin
         check("np_data_pop_nonempty", np_dat_q.size() != 0, 1'b1);
         if (np_dat_q.size() != 0) void'(np_dat_q.pop_front());
         n_np_dat++;
      end
      bus.i_seq_empty     = (seq_q.size() == 0);
      bus.i_seq_type      = (seq_q.size() != 0) ? seq_q[0] : 1'b0;
      bus.i_p_hdr_empty   = (p_hdr_q.size() == 0);
      bus.i_p_hdr         = (p_hdr_q.size() != 0) ? p_hdr_q[0] : '0;
      bus.i_np_hdr_empty  = (np_hdr_q.size() == 0);
      bus.i_np_hdr        = (np_hdr_q.size() != 0) ? np_hdr_q[0] : '0;
      bus.i_p_data_empty  = (p_dat_q.size() == 0);
      bus.i_p_data        = (p_dat_q.size() != 0) ? p_dat_q[0] : '0;
      bus.i_np_data_empty = (np_dat_q.size() == 0);
      bus.i_np_data       = (np_dat_q.size() != 0) ? np_dat_q[0] : '0;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [HW-1:0] h, hs;
      int s0, ph0, pd0, nh0, nd0, base;

      bus.i_tlp_ready = 1'b1;

      // Reset: FIFOs already hold an NP MRd, yet no pop or output may appear.
      send_tlp(1'b1, 3'b000, 10'd1, 16'h0001, 1'b1, h);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("rst_outputs", {bus.o_tlp_valid, bus.o_cr_valid, bus.o_seq_r_inc,
                               bus.o_np_hdr_r_inc, bus.o_p_hdr_r_inc}, 5'b0);
         check("rst_data", bus.o_tlp_data, '0);
      end
      @(posedge clk); #2;
      n_rst = 1'b1;
      wait_done("np_mrd_done", 40);
      check("np_mrd_pops", {8'(n_seq), 8'(n_np_hdr), 8'(n_np_dat), 8'(n_p_hdr)}, {8'd1, 8'd1, 8'd0, 8'd0});

      // P MWr, 16 DW: header + 2 beats, 4 credits.
      s0 = n_seq; ph0 = n_p_hdr; pd0 = n_p_dat;
      send_tlp(1'b0, 3'b010, 10'd16, 16'h0002, 1'b1, h);
      wait_done("p_mwr16_done", 40);
      check("p_mwr16_pops", {8'(n_seq - s0), 8'(n_p_hdr - ph0), 8'(n_p_dat - pd0)}, {8'd1, 8'd1, 8'd2});

      // P, NP, P with the NP header late: nothing may pass the NP head.
      send_tlp(1'b0, 3'b010, 10'd8, 16'h0003, 1'b1, h);
      send_tlp(1'b1, 3'b000, 10'd1, 16'h0004, 1'b0, hs);
      send_tlp(1'b0, 3'b011, 10'd4, 16'h0005, 1'b1, h);
      for (int i = 0; i < 40; i++) begin
         if (exp_beats.size() == 3 && exp_cr.size() == 2) break;
         @(posedge clk);
      end
      check("first_p_done", {8'(exp_beats.size()), 8'(exp_cr.size())}, {8'd3, 8'd2});
      ph0 = n_p_hdr;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("blocked_valid", {bus.o_tlp_valid, bus.o_p_hdr_r_inc, bus.o_seq_r_inc}, 3'b0);
      end
      @(posedge clk); #2;
      check("blocked_p_hdr_pops", n_p_hdr - ph0, 0);
      np_hdr_q.push_back(hs);
      wait_done("p_np_p_done", 60);

      // Length 0 = 1024 DW: 128 beats, 256 credits.
      send_tlp(1'b0, 3'b010, 10'd0, 16'h0006, 1'b1, h);
      wait_done("len1024_done", 400);

      // Backpressure in HDR and on data beat 3 of a 4-beat TLP.
      bus.i_tlp_ready = 1'b0;
      base = acc_cnt;
      send_tlp(1'b0, 3'b010, 10'd32, 16'h0007, 1'b1, h);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.o_tlp_valid === 1'b1) break;
      end
      ph0 = n_p_hdr; pd0 = n_p_dat; s0 = n_seq;
      for (int k = 0; k < 5; k++) begin
         check("hdr_stall_flags", {bus.o_tlp_valid, bus.o_tlp_sop, bus.o_tlp_is_hdr, bus.o_tlp_eop}, 4'b1110);
         check("hdr_stall_data", bus.o_tlp_data, {128'h0, h});
         @(negedge clk);
      end
      @(posedge clk); #2;
      check("hdr_stall_pops", {8'(n_p_hdr - ph0), 8'(n_p_dat - pd0), 8'(n_seq - s0)}, 24'h0);
      bus.i_tlp_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (acc_cnt == base + 3) break;
         @(posedge clk); #2;
      end
      bus.i_tlp_ready = 1'b0;
      pd0 = n_p_dat;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("beat3_stall_flags", {bus.o_tlp_valid, bus.o_tlp_is_hdr, bus.o_tlp_eop}, 3'b100);
         check("beat3_stall_data", bus.o_tlp_data, pat(16'h0007, 2));
      end
      @(posedge clk); #2;
      check("beat3_stall_pops", n_p_dat - pd0, 0);
      bus.i_tlp_ready = 1'b1;
      wait_done("stall_done", 40);

      // Reset during beat 2 of a 4-beat TLP.
      base = acc_cnt;
      send_tlp(1'b0, 3'b010, 10'd32, 16'h0008, 1'b1, h);
      for (int i = 0; i < 20; i++) begin
         if (acc_cnt == base + 2) break;
         @(posedge clk); #2;
      end
      n_rst = 1'b0;
      #1;
      check("midrst_outputs", {bus.o_tlp_valid, bus.o_tlp_sop, bus.o_tlp_eop, bus.o_tlp_is_hdr,
                               bus.o_cr_valid, bus.o_p_data_r_inc, bus.o_seq_r_inc}, 7'b0);
      check("midrst_data", bus.o_tlp_data, '0);
      exp_beats.delete();
      exp_cr.delete();
      p_dat_q.delete();
      send_tlp(1'b1, 3'b001, 10'd2, 16'h0009, 1'b1, h);
      send_tlp(1'b0, 3'b010, 10'd8, 16'h000A, 1'b1, h);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("in_rst_no_pop", {bus.o_seq_r_inc, bus.o_np_hdr_r_inc, bus.o_tlp_valid}, 3'b0);
      end
      @(posedge clk); #2;
      n_rst = 1'b1;
      wait_done("post_rst_done", 60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
